// File: rtl/boot_program_loader_pkg.sv
// rtl/boot_program_loader_pkg.sv - shared state encoding and sizing constants for the boot program loader
package boot_program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_e;

  localparam int LOADER_LEN_BYTES = 2;
  localparam int WORD_BYTES       = 4;
  localparam int LEN_W            = LOADER_LEN_BYTES * 8;

endpackage

// File: rtl/loader_word_assembler.sv
// rtl/loader_word_assembler.sv - big-endian byte-to-word assembler with 2-bit byte index
module loader_word_assembler
  import boot_program_loader_pkg::*;
(
  input  logic        clk1,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [23:0] shift_q;
  logic [1:0]  idx_q;

  // The word is presented combinationally with its last byte so the caller registers it on the accept edge.
  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = byte_valid_i && (idx_q == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (clr_i) begin
      idx_q   <= '0;
    end else if (byte_valid_i) begin
      shift_q <= {shift_q[15:0], byte_i};
      idx_q   <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/boot_program_loader.sv
// rtl/boot_program_loader.sv - streams a length-prefixed program into memory and holds the core in reset (option: LOADER_CHECKSUM_EN)
module boot_program_loader
  import boot_program_loader_pkg::*;
#(
  parameter int unsigned       MEM_AW    = 32,
  parameter logic [MEM_AW-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 1024
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              mem_wren,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wrdata,
  output logic              core_rst,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  words_loaded
);

  localparam logic [31:0] MAX_LEN = 32'(MAX_WORDS);
`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e END_ST = CHK;
`else
  localparam loader_state_e END_ST = DONE;
`endif

  loader_state_e     state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  words_q, words_d;
  logic              mem_wren_q, mem_wren_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wrdata_q, mem_wrdata_d;
  logic              core_rst_q, done_q, err_q;
  logic              accept, restart, asm_valid;
  logic [31:0]       asm_word;
  logic [LEN_W-1:0]  len_rx;

  assign rx_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                    (state_q == DATA)   || (state_q == CHK);
  assign accept   = rx_valid && rx_ready;
  assign restart  = load_req && ((state_q == DONE) || (state_q == ERR));
  assign len_rx   = {len_q[15:8], rx_byte};

  loader_word_assembler u_asm (
    .clk1         (clk1),
    .rst          (rst),
    .clr_i        (restart),
    .byte_valid_i (accept && (state_q == DATA)),
    .byte_i       (rx_byte),
    .word_o       (asm_word),
    .word_valid_o (asm_valid)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d, chk_total;
  assign chk_total = sum_q + rx_byte;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end
`endif

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    words_d      = words_q;
    mem_wren_d   = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wrdata_d = mem_wrdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = LEN_HI;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = '0;
`endif
      end
      LEN_HI: if (accept) begin
        len_d[15:8] = rx_byte;
        state_d     = LEN_LO;
      end
      LEN_LO: if (accept) begin
        len_d = len_rx;
        if ({16'd0, len_rx} > MAX_LEN) state_d = ERR;
        else if (len_rx == '0)         state_d = END_ST;
        else                           state_d = DATA;
      end
      DATA: if (accept) begin
`ifdef LOADER_CHECKSUM_EN
        sum_d = sum_q + rx_byte;
`endif
        if (asm_valid) begin
          mem_wren_d   = 1'b1;
          mem_addr_d   = BASE_ADDR + MEM_AW'(words_q);
          mem_wrdata_d = asm_word;
          words_d      = words_q + 1'b1;
          if (words_d == len_q) state_d = END_ST;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: if (accept) begin
        state_d = (chk_total == 8'h00) ? DONE : ERR;
      end
`endif
      DONE, ERR: if (load_req) begin
        state_d = IDLE;
        words_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decode the next state so they change on the same edge as the state register.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      words_q      <= '0;
      mem_wren_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wrdata_q <= '0;
      core_rst_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      words_q      <= words_d;
      mem_wren_q   <= mem_wren_d;
      mem_addr_q   <= mem_addr_d;
      mem_wrdata_q <= mem_wrdata_d;
      core_rst_q   <= (state_d != DONE);
      done_q       <= (state_d == DONE);
      err_q        <= (state_d == ERR);
    end
  end

  assign mem_wren     = mem_wren_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wrdata   = mem_wrdata_q;
  assign core_rst     = core_rst_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: doc/boot_program_loader.md
Name: boot_program_loader

Overview:
- Sits upstream of the five-stage core and its unified memory; fills memory with a program before the core runs.
- Consumes a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word to consecutive word addresses.
- Holds the core in reset until the load completes.

Parameters:
- MEM_AW, 32, width of mem_addr (word address, matching the PC+1 word-addressed convention).
- BASE_ADDR, 0, word address of the first program word.
- MAX_WORDS, 1024, largest accepted word count; larger counts are an error.

Ports:
- clk1  input  1  system clock (same phase as fetch/writeback and memory write).
- rst  input  1  asynchronous, active-high reset.
- rx_valid  input  1  rx_byte holds a valid byte.
- rx_byte  input  8  stream byte.
- rx_ready  output  1  loader can accept a byte.
- load_req  input  1  one-cycle pulse; restarts a load from DONE or ERR.
- mem_wren  output  1  memory write strobe, one cycle per word.
- mem_addr  output  MEM_AW  word write address.
- mem_wrdata  output  32  word write data.
- core_rst  output  1  reset to the pipeline; high until DONE.
- done  output  1  load completed successfully.
- err  output  1  load failed.
- words_loaded  output  16  count of words written in the current load.

Behaviour:
- Reset values: state IDLE, rx_ready=0, mem_wren=0, mem_addr=0, mem_wrdata=0, core_rst=1, done=0, err=0, words_loaded=0, internal byte index 0.
- Reset mid-load aborts immediately to the reset values; partially written memory is left as is.
- Byte accepted only on a clk1 edge with rx_valid && rx_ready.
- rx_ready=1 in LEN_HI, LEN_LO, DATA and CHK; 0 in IDLE, DONE and ERR.
- Stream format: LEN_HI, LEN_LO (16-bit word count N), then N×4 data bytes, MSB first.
- States and transitions:
  - IDLE: one cycle after reset release (or after load_req), goes to LEN_HI.
  - LEN_HI: on accept, latch len[15:8]; go to LEN_LO.
  - LEN_LO: on accept, latch len[7:0], then:
    - N > MAX_WORDS → ERR.
    - N == 0 → CHK if CHECKSUM_EN, else DONE.
    - Otherwise → DATA.
  - DATA: shift bytes into a 32-bit assembly register; byte index 0..3, wraps after 3.
    - On the 4th byte accept, the next clk1 edge registers mem_wren=1, mem_addr=BASE_ADDR+words_loaded, mem_wrdata=assembled word, and increments words_loaded.
    - Write latency: exactly 1 cycle after the 4th byte is accepted.
    - mem_wren is a single-cycle pulse.
    - Back-to-back bytes are permitted every cycle; no stall is needed.
    - After word N is written → CHK (macro on) or DONE.
  - DONE: core_rst=0, done=1, both held. load_req → IDLE with core_rst=1, done=0, words_loaded=0.
  - ERR: core_rst=1, err=1, both held. load_req → IDLE with err=0.
- load_req is ignored in states other than DONE and ERR.
- rx_valid is ignored while rx_ready=0.
- mem_addr wraps modulo 2^MEM_AW.
- core_rst is registered and never glitches.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit sum (mod 256) accumulates every data byte.
  - CHK state accepts one trailer byte; if sum + trailer == 8'h00 → DONE, else → ERR.
  - N==0 still requires a trailer, which must be 8'h00.
- Undefined: no CHK state, no accumulator, and no trailer byte is expected; the last data word goes straight to DONE.

Decomposition:
- Shared package holds:
  - State encoding typedef: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR.
  - Constant LOADER_LEN_BYTES=2.
  - Constant WORD_BYTES=4.
- One natural sub-module, loader_word_assembler: byte shift register plus 2-bit byte index, with a word_valid output.
- The FSM, counter and memory-write registers stay in boot_program_loader.

Test Plan:
- Stream 00 02 | 11 22 33 44 | AA BB CC DD, rx_valid held high, macro off → mem_wren pulses at addr 0 with data 32'h11223344, then at addr 1 with 32'hAABBCCDD; done=1, core_rst=0, words_loaded=2.
- Same stream with rx_valid toggling 1-0-1-0 → identical writes; each write occurs exactly 1 cycle after its 4th accepted byte.
- Header 04 01 with MAX_WORDS=1024 → ERR after LEN_LO; err=1, core_rst=1, no mem_wren; a load_req pulse then returns to LEN_HI with err=0.
- Macro on, stream 00 01 | 01 02 03 04 | F6 → done=1; same stream with trailer F5 → err=1, core_rst stays 1.
- rst asserted after 2 data bytes → all outputs return to reset values asynchronously; a fresh 00 01 | DE AD BE EF load then writes 32'hDEADBEEF at BASE_ADDR.
- Header 00 00, macro off → DONE in the cycle after LEN_LO with zero writes; macro on, trailer 00 → DONE.
